// File: rtl/shift_datapath.sv
// Working register beside the load/shift controller; R7 feeds back as status.
// Build option SHIFT_DATAPATH_ROTATE_EN turns the shift command into a left rotate.
module shift_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             L,
  input  logic             S,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] R,
  output logic             R7,
  output logic             done,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             seq_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic load_cmd, shift_cmd;
  logic loaded;
  logic fill;

  // Case-equality keeps an undriven S from acting as either command.
  assign load_cmd  = L && (S === 1'b1);
  assign shift_cmd = L && (S === 1'b0);

`ifdef SHIFT_DATAPATH_ROTATE_EN
  assign fill = R[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  assign R7 = R[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      R         <= '0;
      done      <= 1'b0;
      load_cnt  <= '0;
      shift_cnt <= '0;
      seq_err   <= 1'b0;
      loaded    <= 1'b0;
    end else begin
      done <= shift_cmd;
      if (load_cmd) begin
        R      <= din;
        loaded <= 1'b1;
        if (load_cnt != CNT_MAX) load_cnt <= load_cnt + CNT_ONE;
      end else if (shift_cmd) begin
        R <= {R[WIDTH-2:0], fill};
        if (shift_cnt != CNT_MAX) shift_cnt <= shift_cnt + CNT_ONE;
        if (!loaded) seq_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_datapath.sv
// Directed vector table plus counter saturation sequence for shift_datapath.
module tb_shift_datapath;

  logic       clk = 1'b0;
  logic       reset, L, S;
  logic [7:0] din;
  logic [7:0] R, load_cnt, shift_cnt;
  logic       R7, done, seq_err;

  int tests = 0;
  int fails = 0;

  shift_datapath #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .L(L), .S(S), .din(din),
    .R(R), .R7(R7), .done(done),
    .load_cnt(load_cnt), .shift_cnt(shift_cnt), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

`ifdef SHIFT_DATAPATH_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct packed {
    logic       rst, l, s;
    logic [7:0] din;
    logic [7:0] r;
    logic       r7, done;
    logic [7:0] lc, sc;
    logic       err;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got {R,R7,done,lc,sc,err}=%h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] outs();
    return {R, R7, done, load_cnt, shift_cnt, seq_err};
  endfunction

  task automatic step(input logic rst, input logic l, input logic s, input logic [7:0] d);
    reset = rst; L = l; S = s; din = d;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] r4, r6, r7v, r16;
    r4  = ROT ? 8'h4B : 8'h4A;
    r6  = ROT ? 8'h96 : 8'h94;
    r7v = ROT ? 8'h2D : 8'h28;
    r16 = ROT ? 8'h01 : 8'h00;

    //            rst  L    S    din    R      R7   done lc     sc     err
    tbl[0]  = '{1'b0,1'b1,1'b1,8'hFF, 8'h00, 1'b0,1'b0,8'd0,  8'd0,  1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1,8'hFF, 8'h00, 1'b0,1'b0,8'd0,  8'd0,  1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b1,8'h00, 8'h00, 1'b0,1'b0,8'd0,  8'd0,  1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b1,8'hA5, 8'hA5, 1'b1,1'b0,8'd1,  8'd0,  1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,8'h00, r4,    1'b0,1'b1,8'd1,  8'd1,  1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b0,8'hFF, r4,    1'b0,1'b0,8'd1,  8'd1,  1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b0,8'h00, r6,    1'b1,1'b1,8'd1,  8'd2,  1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b0,8'h00, r7v,   1'b0,1'b1,8'd1,  8'd3,  1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b1,8'h11, r7v,   1'b0,1'b0,8'd1,  8'd3,  1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b0,8'h00, 8'h00, 1'b0,1'b0,8'd0,  8'd0,  1'b0};
    tbl[10] = '{1'b1,1'b1,1'b0,8'h00, 8'h00, 1'b0,1'b1,8'd0,  8'd1,  1'b1};
    tbl[11] = '{1'b1,1'b1,1'b1,8'h3C, 8'h3C, 1'b0,1'b0,8'd1,  8'd1,  1'b1};
    tbl[12] = '{1'b0,1'b0,1'b0,8'h00, 8'h00, 1'b0,1'b0,8'd0,  8'd0,  1'b0};
    tbl[13] = '{1'b1,1'b1,1'b0,8'h00, 8'h00, 1'b0,1'b1,8'd0,  8'd1,  1'b1};
    tbl[14] = '{1'b0,1'b0,1'b0,8'h00, 8'h00, 1'b0,1'b0,8'd0,  8'd0,  1'b0};
    tbl[15] = '{1'b1,1'b1,1'b1,8'h80, 8'h80, 1'b1,1'b0,8'd1,  8'd0,  1'b0};
    tbl[16] = '{1'b1,1'b1,1'b0,8'h00, r16,   1'b0,1'b1,8'd1,  8'd1,  1'b0};
    tbl[17] = '{1'b1,1'b1,1'b1,8'h7F, 8'h7F, 1'b0,1'b0,8'd2,  8'd1,  1'b0};
    tbl[18] = '{1'b1,1'b0,1'b0,8'h00, 8'h7F, 1'b0,1'b0,8'd2,  8'd1,  1'b0};

    reset = 1'b0; L = 1'b0; S = 1'b0; din = '0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst, tbl[i].l, tbl[i].s, tbl[i].din);
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].r, tbl[i].r7, tbl[i].done, tbl[i].lc, tbl[i].sc, tbl[i].err});
    end

    // Load counter saturation, then shift counter saturation, then reset.
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 1'b1, 1'b1, i[7:0]);
      if (i == 254) chk("load_cnt_254", {19'd0, load_cnt}, {19'd0, 8'hFE});
      if (i == 255) chk("load_cnt_255", {19'd0, load_cnt}, {19'd0, 8'hFF});
    end
    chk("load_cnt_sat", {19'd0, load_cnt}, {19'd0, 8'hFF});
    chk("last_load_R", {19'd0, R}, {19'd0, 8'd44});
    for (int i = 1; i <= 260; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      if (i == 255) chk("shift_cnt_255", {19'd0, shift_cnt}, {19'd0, 8'hFF});
    end
    chk("shift_cnt_sat", {18'd0, seq_err, shift_cnt}, {18'd0, 1'b0, 8'hFF});
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    chk("sat_reset", outs(), 27'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
